// File: rtl/nn_weight_loader.sv
// nn_weight_loader: streams exactly ChainLength weight words into the simple_nn scan chain
// and hands back the words displaced from the chain tail on a readback stream.
module nn_weight_loader #(
    parameter  int DataWidth   = 8,
    parameter  int ChainLength = 41,
    localparam int CntWidth    = $clog2(ChainLength + 1)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CntWidth-1:0]  count_o,
    input  logic [DataWidth-1:0] wt_data_i,
    input  logic                 wt_valid_i,
    output logic                 wt_ready_o,
    output logic [DataWidth-1:0] rb_data_o,
    output logic                 rb_valid_o,
    input  logic                 rb_ready_i,
    output logic                 shift_o,
    output logic [DataWidth-1:0] scan_do,
    input  logic [DataWidth-1:0] scan_di
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    localparam logic [CntWidth-1:0] LastCount = CntWidth'(ChainLength - 1);

    state_t state;
    state_t state_next;
    logic   fire;

    // A shift is only allowed when the readback slot is free or being drained this cycle,
    // so a displaced tail word is never overwritten. Reset also blocks a shift in its own cycle.
    assign wt_ready_o = (state == LOAD) && !reset_i && (!rb_valid_o || rb_ready_i);
    assign fire       = wt_valid_i && wt_ready_o;
    assign shift_o    = fire;
    assign scan_do    = wt_data_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                busy_o = 1'b1;
                if (fire && (count_o == LastCount)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_o     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The count is held after a load so software can read how far it got.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_o <= '0;
        end else if ((state == IDLE) && start_i) begin
            count_o <= '0;
        end else if (fire) begin
            count_o <= count_o + CntWidth'(1);
        end
    end

    // scan_di is the tail stage before this edge's shift, i.e. the word being pushed out.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rb_valid_o <= 1'b0;
            rb_data_o  <= '0;
        end else if (fire) begin
            rb_valid_o <= 1'b1;
            rb_data_o  <= scan_di;
        end else if (rb_ready_i) begin
            rb_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nn_weight_loader.sv
// tb_nn_weight_loader: randomized self-checking bench for nn_weight_loader with a 4-stage
// scan chain model and a queue-based reference of the chain contents.
module tb_nn_weight_loader;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;
    logic [DW-1:0] wt_data;
    logic          wt_valid;
    logic          wt_ready;
    logic [DW-1:0] rb_data;
    logic          rb_valid;
    logic          rb_ready;
    logic          shift;
    logic [DW-1:0] scan_do;
    logic [DW-1:0] scan_di;

    int check_cnt = 0;
    int pass_cnt  = 0;

    // Reference: chain contents as a FIFO, front = tail stage (next word to be displaced).
    logic [DW-1:0] model_q[$];

    logic          env_init;
    logic [DW-1:0] init_words[N];
    logic [DW-1:0] chain[N];

    always #5 clk = ~clk;

    nn_weight_loader #(
        .DataWidth  (DW),
        .ChainLength(N)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .start_i   (start),
        .busy_o    (busy),
        .done_o    (done),
        .count_o   (count),
        .wt_data_i (wt_data),
        .wt_valid_i(wt_valid),
        .wt_ready_o(wt_ready),
        .rb_data_o (rb_data),
        .rb_valid_o(rb_valid),
        .rb_ready_i(rb_ready),
        .shift_o   (shift),
        .scan_do   (scan_do),
        .scan_di   (scan_di)
    );

    // Stand-in for the simple_nn scan chain: stage 0 takes scan_do, stage N-1 is the tail.
    always @(posedge clk) begin
        if (env_init) begin
            for (int i = 0; i < N; i++) chain[i] <= init_words[i];
        end else if (shift) begin
            chain[0] <= scan_do;
            for (int i = 1; i < N; i++) chain[i] <= chain[i-1];
        end
    end
    assign scan_di = chain[N-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; wt_valid = 1'b1; start = 1'b0; rb_ready = 1'b1;
        wt_data = 8'h00; env_init = 1'b1;
        tick();
        env_init = 1'b0;
        tick();
        #1;
        check_cnt++;
        if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
        check_cnt++;
        if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else pass_cnt++;
        check_cnt++;
        if (rb_valid !== 1'b0) $display("[TB] FAIL reset_rb_valid: got %b expected 0", rb_valid); else pass_cnt++;
        check_cnt++;
        if (rb_data !== 8'h00) $display("[TB] FAIL reset_rb_data: got %h expected 00", rb_data); else pass_cnt++;
        check_cnt++;
        if (count !== CW'(0)) $display("[TB] FAIL reset_count: got %0d expected 0", count); else pass_cnt++;
        check_cnt++;
        if (shift !== 1'b0) $display("[TB] FAIL reset_shift: got %b expected 0", shift); else pass_cnt++;
        reset = 1'b0;
        tick();
        #1;
        check_cnt++;
        if (shift !== 1'b0 || wt_ready !== 1'b0)
            $display("[TB] FAIL idle_no_shift: got shift=%b ready=%b expected 0/0", shift, wt_ready);
        else pass_cnt++;
        wt_valid = 1'b0;
        tick();
    endtask

    task automatic test_full_load();
        logic [DW-1:0] words[N];
        logic [DW-1:0] exp_rb;
        words = '{8'h11, 8'h12, 8'h13, 8'h14};
        rb_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check_cnt++;
        if (busy !== 1'b1) $display("[TB] FAIL full_busy: got %b expected 1", busy); else pass_cnt++;
        for (int k = 0; k < N; k++) begin
            wt_data = words[k]; wt_valid = 1'b1;
            #1;
            check_cnt++;
            if (shift !== 1'b1) $display("[TB] FAIL full_shift%0d: got %b expected 1", k, shift); else pass_cnt++;
            check_cnt++;
            if (scan_do !== words[k]) $display("[TB] FAIL full_scan_do%0d: got %h expected %h", k, scan_do, words[k]); else pass_cnt++;
            exp_rb = model_q.pop_front();
            model_q.push_back(words[k]);
            tick();
            check_cnt++;
            if (rb_valid !== 1'b1 || rb_data !== exp_rb)
                $display("[TB] FAIL full_rb%0d: got v=%b d=%h expected v=1 d=%h", k, rb_valid, rb_data, exp_rb);
            else pass_cnt++;
            check_cnt++;
            if (count !== CW'(k + 1)) $display("[TB] FAIL full_count%0d: got %0d expected %0d", k, count, k + 1); else pass_cnt++;
        end
        wt_valid = 1'b0;
        check_cnt++;
        if (done !== 1'b1 || busy !== 1'b0)
            $display("[TB] FAIL full_done: got done=%b busy=%b expected 1/0", done, busy);
        else pass_cnt++;
        check_cnt++;
        if (count !== CW'(N)) $display("[TB] FAIL full_count_end: got %0d expected %0d", count, N); else pass_cnt++;
        tick();
        check_cnt++;
        if (done !== 1'b0) $display("[TB] FAIL full_done_pulse: got %b expected 0", done); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] words[N];
        logic [DW-1:0] exp_rb;
        for (int i = 0; i < N; i++) words[i] = DW'($urandom);
        rb_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wt_data = words[0]; wt_valid = 1'b1;
        exp_rb = model_q.pop_front();
        model_q.push_back(words[0]);
        tick();
        rb_ready = 1'b0; wt_data = words[1];
        for (int c = 0; c < 3; c++) begin
            #1;
            check_cnt++;
            if (wt_ready !== 1'b0 || shift !== 1'b0)
                $display("[TB] FAIL bp_stall%0d: got ready=%b shift=%b expected 0/0", c, wt_ready, shift);
            else pass_cnt++;
            tick();
            check_cnt++;
            if (rb_valid !== 1'b1 || rb_data !== exp_rb)
                $display("[TB] FAIL bp_hold%0d: got v=%b d=%h expected v=1 d=%h", c, rb_valid, rb_data, exp_rb);
            else pass_cnt++;
            check_cnt++;
            if (count !== CW'(1)) $display("[TB] FAIL bp_count%0d: got %0d expected 1", c, count); else pass_cnt++;
        end
        rb_ready = 1'b1;
        for (int k = 1; k < N; k++) begin
            wt_data = words[k];
            #1;
            check_cnt++;
            if (shift !== 1'b1) $display("[TB] FAIL bp_resume%0d: got %b expected 1", k, shift); else pass_cnt++;
            exp_rb = model_q.pop_front();
            model_q.push_back(words[k]);
            tick();
            check_cnt++;
            if (rb_data !== exp_rb) $display("[TB] FAIL bp_rb%0d: got %h expected %h", k, rb_data, exp_rb); else pass_cnt++;
        end
        wt_valid = 1'b0;
        check_cnt++;
        if (done !== 1'b1 || count !== CW'(N))
            $display("[TB] FAIL bp_done: got done=%b count=%0d expected 1/%0d", done, count, N);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_ignore_start();
        logic [DW-1:0] w;
        rb_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (k == 2) begin
                wt_valid = 1'b0; start = 1'b1;
                tick();
                start = 1'b0;
                check_cnt++;
                if (busy !== 1'b1 || count !== CW'(2))
                    $display("[TB] FAIL ign_load_start: got busy=%b count=%0d expected 1/2", busy, count);
                else pass_cnt++;
            end
            w = DW'($urandom);
            wt_data = w; wt_valid = 1'b1;
            void'(model_q.pop_front());
            model_q.push_back(w);
            tick();
        end
        check_cnt++;
        if (done !== 1'b1) $display("[TB] FAIL ign_done: got %b expected 1", done); else pass_cnt++;
        start = 1'b1; wt_data = DW'($urandom);
        #1;
        check_cnt++;
        if (wt_ready !== 1'b0 || shift !== 1'b0)
            $display("[TB] FAIL ign_done_ready: got ready=%b shift=%b expected 0/0", wt_ready, shift);
        else pass_cnt++;
        tick();
        start = 1'b0;
        check_cnt++;
        if (busy !== 1'b0 || done !== 1'b0 || count !== CW'(N))
            $display("[TB] FAIL ign_done_start: got busy=%b done=%b count=%0d expected 0/0/%0d", busy, done, count, N);
        else pass_cnt++;
        for (int c = 0; c < 2; c++) begin
            #1;
            check_cnt++;
            if (wt_ready !== 1'b0 || shift !== 1'b0)
                $display("[TB] FAIL ign_overrun%0d: got ready=%b shift=%b expected 0/0", c, wt_ready, shift);
            else pass_cnt++;
            tick();
        end
        check_cnt++;
        if (count !== CW'(N)) $display("[TB] FAIL ign_count: got %0d expected %0d", count, N); else pass_cnt++;
        wt_valid = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        logic [DW-1:0] w;
        logic [DW-1:0] exp_rb;
        rb_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            w = DW'($urandom);
            wt_data = w; wt_valid = 1'b1;
            void'(model_q.pop_front());
            model_q.push_back(w);
            tick();
        end
        wt_valid = 1'b0; reset = 1'b1;
        tick();
        check_cnt++;
        if (busy !== 1'b0 || rb_valid !== 1'b0 || rb_data !== 8'h00 || count !== CW'(0))
            $display("[TB] FAIL mid_reset: got busy=%b rbv=%b rbd=%h count=%0d expected 0/0/00/0", busy, rb_valid, rb_data, count);
        else pass_cnt++;
        reset = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            w = DW'($urandom);
            wt_data = w; wt_valid = 1'b1;
            exp_rb = model_q.pop_front();
            model_q.push_back(w);
            tick();
            check_cnt++;
            if (rb_data !== exp_rb) $display("[TB] FAIL mid_fresh_rb%0d: got %h expected %h", k, rb_data, exp_rb); else pass_cnt++;
        end
        wt_valid = 1'b0;
        check_cnt++;
        if (done !== 1'b1 || count !== CW'(N))
            $display("[TB] FAIL mid_fresh_done: got done=%b count=%0d expected 1/%0d", done, count, N);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reload();
        logic [DW-1:0] a_words[N];
        logic [DW-1:0] b_words[N];
        logic [DW-1:0] exp_rb;
        a_words = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        b_words = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
        rb_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        exp_rb = 8'h00;
        for (int k = 0; k < N; k++) begin
            wt_data = a_words[k]; wt_valid = 1'b1;
            exp_rb = model_q.pop_front();
            model_q.push_back(a_words[k]);
            tick();
        end
        wt_valid = 1'b0; rb_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check_cnt++;
            if (rb_valid !== 1'b1 || rb_data !== exp_rb)
                $display("[TB] FAIL drain_hold%0d: got v=%b d=%h expected v=1 d=%h", c, rb_valid, rb_data, exp_rb);
            else pass_cnt++;
            tick();
        end
        rb_ready = 1'b1;
        tick();
        check_cnt++;
        if (rb_valid !== 1'b0) $display("[TB] FAIL drain_release: got %b expected 0", rb_valid); else pass_cnt++;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            wt_data = b_words[k]; wt_valid = 1'b1;
            void'(model_q.pop_front());
            model_q.push_back(b_words[k]);
            tick();
            check_cnt++;
            if (rb_data !== a_words[k]) $display("[TB] FAIL reload_rb%0d: got %h expected %h", k, rb_data, a_words[k]); else pass_cnt++;
        end
        wt_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int            phase;
        int            cnt;
        int            budget;
        logic          exp_rbv;
        logic [DW-1:0] exp_rb;
        logic          exp_ready;
        logic          fire;
        rb_ready = 1'b1; wt_valid = 1'b0; start = 1'b0;
        tick();
        exp_rbv = 1'b0;
        exp_rb  = 8'h00;
        for (int l = 0; l < 3; l++) begin
            start = 1'b1; wt_valid = 1'b0;
            tick();
            start = 1'b0;
            phase = 1; cnt = 0; budget = 0;
            while (phase != 0 && budget < 200) begin
                wt_valid = ($urandom_range(0, 3) != 0);
                wt_data  = DW'($urandom);
                rb_ready = ($urandom_range(0, 2) != 0);
                start    = ($urandom_range(0, 7) == 0);
                #1;
                exp_ready = (phase == 1) && (!exp_rbv || rb_ready);
                fire      = wt_valid && exp_ready;
                check_cnt++;
                if (wt_ready !== exp_ready || shift !== fire)
                    $display("[TB] FAIL rand_hs: got ready=%b shift=%b expected %b/%b", wt_ready, shift, exp_ready, fire);
                else pass_cnt++;
                if (fire) begin
                    exp_rb = model_q.pop_front();
                    model_q.push_back(wt_data);
                    exp_rbv = 1'b1;
                    cnt++;
                end else if (rb_ready) begin
                    exp_rbv = 1'b0;
                end
                if (phase == 2) phase = 0;
                else if (phase == 1 && cnt == N) phase = 2;
                tick();
                budget++;
                check_cnt++;
                if (rb_valid !== exp_rbv || (exp_rbv && rb_data !== exp_rb))
                    $display("[TB] FAIL rand_rb: got v=%b d=%h expected v=%b d=%h", rb_valid, rb_data, exp_rbv, exp_rb);
                else pass_cnt++;
                check_cnt++;
                if (count !== CW'(cnt) || busy !== (phase == 1) || done !== (phase == 2))
                    $display("[TB] FAIL rand_state: got count=%0d busy=%b done=%b expected %0d/%b/%b", count, busy, done, cnt, phase == 1, phase == 2);
                else pass_cnt++;
            end
            start = 1'b0;
            check_cnt++;
            if (phase != 0) $display("[TB] FAIL rand_timeout: got %0d cycles expected completion under 200", budget);
            else pass_cnt++;
        end
        wt_valid = 1'b0; rb_ready = 1'b1;
        tick();
    endtask

    initial begin
        for (int i = 0; i < N; i++) init_words[i] = DW'($urandom);
        for (int i = N - 1; i >= 0; i--) model_q.push_back(init_words[i]);
        test_reset();
        test_full_load();
        test_backpressure();
        test_ignore_start();
        test_reset_mid_load();
        test_reload();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
